// File: rtl/eth_mdio_ctrl.sv
// MDIO (clause 22) management master: one 64-bit frame per start edge.
// Optional debug bus enabled by defining ETH_MDIO_DBG_EN.
module eth_mdio_ctrl #(
   parameter int unsigned G_DIV = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        usr_start,
   input  logic        usr_dir,
   input  logic [4:0]  usr_aphy,
   input  logic [4:0]  usr_areg,
   input  logic [15:0] usr_txd,
   output logic [15:0] usr_rxd,
   output logic        usr_done,
   output logic        usr_busy,
   output logic        p_out_mdio_t,
   output logic        p_out_mdio,
   input  logic        p_in_mdio,
   output logic        p_out_mdc,
   output logic [31:0] dbg_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FRAME = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [8:0] C_HALF = 9'(G_DIV);
   localparam logic [8:0] C_RISE = 9'(G_DIV - 1);
   localparam logic [8:0] C_LAST = 9'(2 * G_DIV - 1);
   localparam logic [5:0] C_TA   = 6'd46;
   localparam logic [5:0] C_D0   = 6'd48;
   localparam logic [5:0] C_END  = 6'd63;

   state_t      state_q, state_d;
   logic [8:0]  div_q, div_d;
   logic [5:0]  bit_q, bit_d;
   logic [63:0] sh_q, sh_d;
   logic        dir_q, dir_d;
   logic [15:0] rsh_q, rsh_d;
   logic [15:0] rxd_q, rxd_d;
   logic        stp_q;
   logic        arm_q;
   logic        start_edge;
   logic        in_frame;
   logic        mdc_w;
   logic        mdio_w;
   logic        mdio_t_w;

   // Edge detector; arm_q blocks a start held high across reset release
   always_ff @(posedge clk) begin
      if (rst) begin
         stp_q <= 1'b0;
         arm_q <= 1'b0;
      end else begin
         stp_q <= usr_start;
         arm_q <= arm_q | ~usr_start;
      end
   end

   assign start_edge = usr_start & ~stp_q & arm_q;

   // State, counters, shift registers and read-data register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '1;
         dir_q   <= 1'b0;
         rsh_q   <= '0;
         rxd_q   <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         dir_q   <= dir_d;
         rsh_q   <= rsh_d;
         rxd_q   <= rxd_d;
      end
   end

   // Next-state: latch the request, step divider and bit counter
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      dir_d   = dir_q;
      rsh_d   = rsh_q;
      rxd_d   = rxd_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_edge) begin
               state_d = S_FRAME;
               div_d   = '0;
               bit_d   = '0;
               dir_d   = usr_dir;
               sh_d    = {32'hFFFF_FFFF, 2'b01,
                          usr_dir ? 2'b01 : 2'b10,
                          usr_aphy, usr_areg,
                          usr_dir ? 2'b10 : 2'b11,
                          usr_dir ? usr_txd : 16'hFFFF};
            end
         end
         S_FRAME: begin
            if (div_q == C_RISE && !dir_q && bit_q >= C_D0) begin
               rsh_d = {rsh_q[14:0], p_in_mdio};
            end
            if (div_q == C_LAST) begin
               div_d = '0;
               sh_d  = {sh_q[62:0], 1'b1};
               if (bit_q == C_END) begin
                  state_d = S_DONE;
                  bit_d   = '0;
                  if (!dir_q) begin
                     rxd_d = rsh_q;
                  end
               end else begin
                  bit_d = bit_q + 6'd1;
               end
            end else begin
               div_d = div_q + 9'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign in_frame = (state_q == S_FRAME);
   assign mdc_w    = in_frame & (div_q >= C_HALF);
   assign mdio_w   = in_frame ? sh_q[63] : 1'b1;
   assign mdio_t_w = ~(in_frame & (dir_q | (bit_q < C_TA)));

   assign usr_busy     = in_frame;
   assign usr_done     = (state_q == S_DONE);
   assign usr_rxd      = rxd_q;
   assign p_out_mdc    = mdc_w;
   assign p_out_mdio   = mdio_w;
   assign p_out_mdio_t = mdio_t_w;

`ifdef ETH_MDIO_DBG_EN
   assign dbg_o = {18'd0, p_in_mdio, mdio_t_w, mdio_w, mdc_w,
                   bit_q, 2'b00, state_q};
`else
   assign dbg_o = 32'd0;
`endif

endmodule

// File: tb/tb_eth_mdio_ctrl.sv
// Bench for eth_mdio_ctrl: table-driven frames, random frames,
// reset-through-start and mid-frame abort sequences.
module tb_eth_mdio_ctrl;

   localparam int G   = 2;
   localparam int PER = 2 * G;
   localparam int CYC = 128 * G;
   localparam int NV  = 9;

   typedef struct {
      string       nm;
      bit          dir;
      logic [4:0]  ap;
      logic [4:0]  ar;
      logic [15:0] txd;
      logic [15:0] rdat;
      int          hold;
      bit          pulse;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        usr_start = 1'b0;
   logic        usr_dir = 1'b0;
   logic [4:0]  usr_aphy = '0;
   logic [4:0]  usr_areg = '0;
   logic [15:0] usr_txd = '0;
   logic [15:0] usr_rxd;
   logic        usr_done;
   logic        usr_busy;
   logic        p_out_mdio_t;
   logic        p_out_mdio;
   logic        p_in_mdio = 1'b1;
   logic        p_out_mdc;
   logic [31:0] dbg_o;

   int          checks = 0;
   int          failures = 0;
   int          ndone = 0;
   logic [15:0] exp_rxd = '0;

   eth_mdio_ctrl #(.G_DIV(G)) dut (
      .clk          (clk),
      .rst          (rst),
      .usr_start    (usr_start),
      .usr_dir      (usr_dir),
      .usr_aphy     (usr_aphy),
      .usr_areg     (usr_areg),
      .usr_txd      (usr_txd),
      .usr_rxd      (usr_rxd),
      .usr_done     (usr_done),
      .usr_busy     (usr_busy),
      .p_out_mdio_t (p_out_mdio_t),
      .p_out_mdio   (p_out_mdio),
      .p_in_mdio    (p_in_mdio),
      .p_out_mdc    (p_out_mdc),
      .dbg_o        (dbg_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (usr_done === 1'b1) ndone <= ndone + 1;
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected MDIO bit stream, MSB = first bit on the wire
   function automatic logic [63:0] frame_of(input bit dir,
      input logic [4:0] ap, input logic [4:0] ar, input logic [15:0] d);
      return {32'hFFFF_FFFF, 2'b01, dir ? 2'b01 : 2'b10,
              ap, ar, 2'b10, d};
   endfunction

   task automatic idle_chk(input string nm, input int n);
      int e;
      e = 0;
      for (int i = 0; i < n; i++) begin
         if (usr_busy !== 1'b0 || usr_done !== 1'b0) e++;
         if (p_out_mdc !== 1'b0 || p_out_mdio_t !== 1'b1) e++;
         if (p_out_mdio !== 1'b1) e++;
         tick();
      end
      chk(nm, e, 0);
   endtask

   task automatic do_frame(input vec_t v);
      logic [63:0] ef, obs, tob, msk, etv;
      int emdc, ebusy, estab, erxd, d0, b, ph;
      logic cur;
      emdc = 0; ebusy = 0; estab = 0; erxd = 0;
      usr_start = 1'b0;
      tick();
      usr_dir  = v.dir;
      usr_aphy = v.ap;
      usr_areg = v.ar;
      usr_txd  = v.txd;
      usr_start = 1'b1;
      d0 = ndone;
      tick();
      chk({v.nm, "_busy_rise"}, usr_busy, 1);
      usr_dir  = ~v.dir;
      usr_aphy = 5'($urandom);
      usr_areg = 5'($urandom);
      usr_txd  = 16'($urandom);
      ef  = frame_of(v.dir, v.ap, v.ar, v.txd);
      msk = v.dir ? '1 : 64'hFFFF_FFFF_FFFC_0000;
      etv = v.dir ? '0 : ~msk;
      obs = '0; tob = '0; cur = 1'b0;
      for (int k = 0; k < CYC; k++) begin
         b  = k / PER;
         ph = k % PER;
         if (k == v.hold) usr_start = 1'b0;
         if (v.pulse && k == 100) usr_start = 1'b1;
         if (v.pulse && k == 104) usr_start = 1'b0;
         p_in_mdio = (b >= 48) ? v.rdat[63 - b] : 1'($urandom);
         if (ph == 0) begin
            obs[63 - b] = p_out_mdio;
            tob[63 - b] = p_out_mdio_t;
            cur = p_out_mdio;
         end else begin
            if (msk[63 - b] && p_out_mdio !== cur) estab++;
            if (p_out_mdio_t !== tob[63 - b]) estab++;
         end
         if (p_out_mdc !== (ph >= G)) emdc++;
         if (usr_busy !== 1'b1 || usr_done !== 1'b0) ebusy++;
         if (usr_rxd !== exp_rxd) erxd++;
         tick();
      end
      chk({v.nm, "_bits"}, obs & msk, ef & msk);
      chk({v.nm, "_tris"}, tob, etv);
      chk({v.nm, "_mdc_err"}, emdc, 0);
      chk({v.nm, "_stab_err"}, estab, 0);
      chk({v.nm, "_busy_err"}, ebusy, 0);
      chk({v.nm, "_rxd_hold_err"}, erxd, 0);
      if (!v.dir) exp_rxd = v.rdat;
      chk({v.nm, "_done"}, usr_done, 1);
      chk({v.nm, "_busy_end"}, usr_busy, 0);
      chk({v.nm, "_rxd"}, usr_rxd, exp_rxd);
      tick();
      chk({v.nm, "_done_1cyc"}, usr_done, 0);
      idle_chk({v.nm, "_idle"}, 4);
      chk({v.nm, "_ndone"}, ndone - d0, 1);
   endtask

   initial begin
      vec_t tbl[NV];
      vec_t v;
      int   e, d0;

      tbl[0] = '{"wr_8ffa", 1'b1, 5'h06, 5'h0B, 16'h8FFA, 16'h0000, 1, 1'b0};
      tbl[1] = '{"rd_ffff", 1'b0, 5'h06, 5'h0B, 16'h0000, 16'hFFFF, 1, 1'b0};
      tbl[2] = '{"rd_1234", 1'b0, 5'h1A, 5'h03, 16'hBEEF, 16'h1234, 1, 1'b0};
      tbl[3] = '{"wr_keep", 1'b1, 5'h11, 5'h1F, 16'h5A5A, 16'hFFFF, 1, 1'b0};
      tbl[4] = '{"wr_hold", 1'b1, 5'h15, 5'h0A, 16'h0001, 16'h0000, 20, 1'b1};
      for (int i = 5; i < NV; i++) begin
         tbl[i].nm    = $sformatf("rnd%0d", i);
         tbl[i].dir   = 1'($urandom);
         tbl[i].ap    = 5'($urandom);
         tbl[i].ar    = 5'($urandom);
         tbl[i].txd   = 16'($urandom);
         tbl[i].rdat  = 16'($urandom);
         tbl[i].hold  = 1 + int'($urandom_range(0, 30));
         tbl[i].pulse = 1'($urandom);
      end

      rst = 1'b1;
      usr_start = 1'b1;
      repeat (3) tick();
      chk("rst_busy", usr_busy, 0);
      chk("rst_done", usr_done, 0);
      chk("rst_rxd", usr_rxd, 0);
      chk("rst_mdc", p_out_mdc, 0);
      chk("rst_mdio_t", p_out_mdio_t, 1);
      chk("rst_mdio", p_out_mdio, 1);
      chk("rst_dbg", dbg_o, 0);

      rst = 1'b0;
      e = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (usr_busy !== 1'b0) e++;
      end
      chk("start_thru_rst", e, 0);
      chk("start_thru_rst_done", ndone, 0);
      usr_start = 1'b0;
      tick();

      for (int i = 0; i < NV; i++) begin
         do_frame(tbl[i]);
      end

      usr_start = 1'b0;
      tick();
      usr_dir  = 1'b1;
      usr_aphy = 5'h03;
      usr_areg = 5'h04;
      usr_txd  = 16'hA5C3;
      usr_start = 1'b1;
      d0 = ndone;
      tick();
      usr_start = 1'b0;
      chk("abort_busy_rise", usr_busy, 1);
      repeat (20 * PER) tick();
      chk("abort_busy_bit20", usr_busy, 1);
      rst = 1'b1;
      tick();
      chk("abort_busy", usr_busy, 0);
      chk("abort_done", usr_done, 0);
      chk("abort_mdc", p_out_mdc, 0);
      chk("abort_mdio_t", p_out_mdio_t, 1);
      chk("abort_mdio", p_out_mdio, 1);
      chk("abort_rxd", usr_rxd, 0);
      exp_rxd = '0;
      rst = 1'b0;
      idle_chk("abort_idle", 6);
      chk("abort_no_done", ndone - d0, 0);

      v = '{"post_abort", 1'b0, 5'h1F, 5'h00, 16'h0000,
            16'($urandom), 1, 1'b0};
      do_frame(v);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/eth_mdio_ctrl.md
ETH_MDIO_CTRL -- requirements
Module: eth_mdio_ctrl

Interface
REQ-001 The block SHALL have parameter G_DIV, default 8, giving MDC half-period in clk cycles (legal range 1..255).
REQ-002 The block SHALL have ports:
  clk  in  1  single system clock, all logic on rising edge
  rst  in  1  synchronous, active-high reset
  usr_start  in  1  transaction request, rising-edge triggered
  usr_dir  in  1  1 = write (tx), 0 = read (rx)
  usr_aphy  in  5  PHY address
  usr_areg  in  5  register address
  usr_txd  in  16  write data
  usr_rxd  out  16  read data
  usr_done  out  1  one-cycle end-of-transaction pulse
  usr_busy  out  1  transaction in progress
  p_out_mdio_t  out  1  MDIO tristate, 1 = released/high-Z, 0 = driven
  p_out_mdio  out  1  MDIO output value
  p_in_mdio  in  1  MDIO input value
  p_out_mdc  out  1  MDC clock
  dbg_o  out  32  debug bus

Function
REQ-003 Start SHALL be accepted on a 0->1 transition of usr_start (registered edge detect) while idle; holding usr_start high SHALL NOT retrigger.
REQ-004 usr_start edges while usr_busy=1 SHALL be ignored.
REQ-005 On acceptance, usr_dir, usr_aphy, usr_areg, usr_txd SHALL be latched; later input changes SHALL NOT affect the frame.
REQ-006 usr_busy SHALL rise the cycle after the accepted edge and stay high for exactly 128*G_DIV clk cycles.
REQ-007 The frame SHALL be 64 bit-periods, MSB first: 32 preamble ones, ST=01, OP=01 (write) or 10 (read), PHYAD[4:0], REGAD[4:0], TA, DATA[15:0].
REQ-008 Each bit period SHALL be 2*G_DIV cycles: MDC low for the first G_DIV, high for the next G_DIV; p_out_mdio SHALL change only at the start of a period (MDC falling/low).
REQ-009 Write: MDIO driven (t=0) for all 64 bits; TA=10; DATA=latched usr_txd.
REQ-010 Read: MDIO driven for bits 0..45; released (t=1) from TA first bit through bit 63.
REQ-011 Read: p_in_mdio SHALL be sampled on the clk where MDC goes 0->1 during each DATA bit; TA bits not captured.
REQ-012 usr_rxd SHALL update with the 16 captured bits when a read completes; it SHALL hold otherwise, and writes SHALL NOT change it.
REQ-013 usr_done SHALL pulse high for one cycle, the first cycle usr_busy is low after a frame.
REQ-014 Idle: p_out_mdc=0, p_out_mdio_t=1, p_out_mdio=1.
REQ-015 A new accepted start is allowed the cycle after usr_done.
REQ-016 State machine: IDLE -> FRAME (bit counter 0..63, divider 0..2*G_DIV-1) -> DONE (1 cycle) -> IDLE.

Reset
REQ-017 rst=1 SHALL force IDLE, usr_busy=0, usr_done=0, usr_rxd=0, p_out_mdc=0, p_out_mdio_t=1, p_out_mdio=1, clear counters and the edge detector.
REQ-018 rst during a frame SHALL abort it with no usr_done pulse and no usr_rxd update.
REQ-019 usr_start held high through reset release SHALL NOT start a frame (edge detector clears to 1 when rst=1 and usr_start=1? no: detector register resets to 0 and an edge counts only after rst deasserts and usr_start is seen low).

Configuration
REQ-020 Macro ETH_MDIO_DBG_EN defined: dbg_o[3:0]=state, [9:4]=bit counter, [10]=MDC, [11]=mdio out, [12]=mdio_t, [13]=p_in_mdio, rest 0.
REQ-021 Macro undefined: dbg_o SHALL be constant 0 and debug logic omitted.

Verification
REQ-022 G_DIV=2, write aphy=06 areg=0B txd=8FFA -> MDIO bits 32x1,01,01,00110,01011,10,1000111111111010; busy 256 cycles; done pulse; t=0 throughout.
REQ-023 G_DIV=2, read same addresses, p_in_mdio=1 -> OP=10, t=1 from bit 46, usr_rxd=FFFF at done.
REQ-024 Read with p_in_mdio driven by model returning 1234 -> usr_rxd=1234; subsequent write leaves usr_rxd=1234.
REQ-025 usr_start held high 20 cycles, and pulsed again mid-frame -> exactly one frame, one done pulse.
REQ-026 rst asserted at bit 20 -> outputs at reset values next cycle, no done; next start produces a full correct frame.
